// File: rtl/aes_input_packer.sv
// aes_input_packer
// Gathers 32-bit key and plaintext words, most-significant word first, into
// 128-bit key/datain registers for an AES core. A LATENCY-deep shift register
// tracks every issued block independently to produce out_valid, and blk_count
// counts completed blocks modulo 256.

module aes_input_packer #(
    parameter int LATENCY = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  in_word,
    input  logic         in_is_key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] datain,
    output logic [127:0] key,
    output logic         blk_valid,
    output logic         key_valid,
    output logic         out_valid,
    output logic [7:0]   blk_count,
    output logic         err_mix
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] FILL_KEY  = 2'd1;
    localparam logic [1:0] FILL_DATA = 2'd2;
    localparam logic [1:0] ISSUE     = 2'd3;

    // Insert a 32-bit word into slot idx of a 128-bit block; slot 0 is the
    // most-significant word.
    function automatic logic [127:0] place_word(
        input logic [127:0] base,
        input logic [1:0]   idx,
        input logic [31:0]  word
    );
        logic [127:0] res;
        res = base;
        case (idx)
            2'd0:    res[127:96] = word;
            2'd1:    res[95:64]  = word;
            2'd2:    res[63:32]  = word;
            2'd3:    res[31:0]   = word;
            default: res         = base;
        endcase
        return res;
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         wcnt_r;
    logic [127:0]       shadow_r;
    logic [127:0]       datain_r;
    logic [127:0]       key_r;
    logic               key_valid_r;
    logic               blk_valid_r;
    logic               err_mix_r;
    logic [LATENCY-1:0] shift_r;
    logic [7:0]         blk_count_r;

    logic [1:0]   state_s;
    logic [1:0]   wcnt_s;
    logic [127:0] shadow_s;
    logic [127:0] datain_s;
    logic [127:0] key_s;
    logic         key_valid_s;
    logic         blk_valid_s;
    logic         err_mix_s;
    logic         in_ready_s;
    logic         accept_s;
    logic         fill_is_key_s;
    logic [127:0] placed_s;

    // Ready: never during ISSUE; plaintext only once a key exists. The rst
    // term keeps plaintext refused during a reset cycle, because key_valid is
    // being cleared on that edge.
    always_comb begin
        in_ready_s = (state_r != ISSUE) && (in_is_key || (key_valid_r && !rst));
        accept_s   = in_valid && in_ready_s;
    end

    // Next-state, word placement and block/key hand-off logic.
    always_comb begin
        state_s       = state_r;
        wcnt_s        = wcnt_r;
        shadow_s      = shadow_r;
        datain_s      = datain_r;
        key_s         = key_r;
        key_valid_s   = key_valid_r;
        blk_valid_s   = 1'b0;
        err_mix_s     = 1'b0;
        fill_is_key_s = (state_r == FILL_KEY);
        placed_s      = place_word(shadow_r, wcnt_r, in_word);

        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    shadow_s = {in_word, 96'h0};
                    wcnt_s   = 2'd1;
                    state_s  = in_is_key ? FILL_KEY : FILL_DATA;
                end else begin
                    state_s = IDLE;
                end
            end

            FILL_KEY, FILL_DATA: begin
                if (!accept_s) begin
                    state_s = state_r;
                end else if (in_is_key != fill_is_key_s) begin
                    // Type switch mid-block: drop the partial block and
                    // start a fresh one of the new type with this word.
                    err_mix_s = 1'b1;
                    shadow_s  = {in_word, 96'h0};
                    wcnt_s    = 2'd1;
                    state_s   = in_is_key ? FILL_KEY : FILL_DATA;
                end else if (wcnt_r == 2'd3) begin
                    shadow_s = placed_s;
                    wcnt_s   = 2'd0;
                    if (fill_is_key_s) begin
                        key_s       = placed_s;
                        key_valid_s = 1'b1;
                        state_s     = IDLE;
                    end else begin
                        datain_s    = placed_s;
                        blk_valid_s = 1'b1;
                        state_s     = ISSUE;
                    end
                end else begin
                    shadow_s = placed_s;
                    wcnt_s   = wcnt_r + 2'd1;
                end
            end

            ISSUE: begin
                state_s = IDLE;
            end

            default: begin
                state_s = IDLE;
                wcnt_s  = 2'd0;
            end
        endcase
    end

    // Control and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            wcnt_r      <= 2'd0;
            shadow_r    <= 128'h0;
            datain_r    <= 128'h0;
            key_r       <= 128'h0;
            key_valid_r <= 1'b0;
            blk_valid_r <= 1'b0;
            err_mix_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            wcnt_r      <= wcnt_s;
            shadow_r    <= shadow_s;
            datain_r    <= datain_s;
            key_r       <= key_s;
            key_valid_r <= key_valid_s;
            blk_valid_r <= blk_valid_s;
            err_mix_r   <= err_mix_s;
        end
    end

    // Latency pipeline: one bit per cycle so every in-flight block is
    // tracked on its own; reset flushes all of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r <= '0;
        end else begin
            shift_r[0] <= blk_valid_r;
            for (int i = 1; i < LATENCY; i++) begin
                shift_r[i] <= shift_r[i-1];
            end
        end
    end

    // Completed-block counter, wrapping naturally at 256.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_count_r <= 8'd0;
        end else if (shift_r[LATENCY-1]) begin
            blk_count_r <= blk_count_r + 8'd1;
        end else begin
            blk_count_r <= blk_count_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign datain    = datain_r;
    assign key       = key_r;
    assign blk_valid = blk_valid_r;
    assign key_valid = key_valid_r;
    assign out_valid = shift_r[LATENCY-1];
    assign blk_count = blk_count_r;
    assign err_mix   = err_mix_r;

endmodule

// File: tb/tb_aes_input_packer.sv
// Directed self-checking bench for aes_input_packer (LATENCY = 10).

module tb_aes_input_packer;

    localparam int LAT = 10;

    logic         clk;
    logic         rst;
    logic [31:0]  in_word;
    logic         in_is_key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] datain;
    logic [127:0] key;
    logic         blk_valid;
    logic         key_valid;
    logic         out_valid;
    logic [7:0]   blk_count;
    logic         err_mix;

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int blk_q[$];
    int ov_q[$];
    int err_n = 0;

    aes_input_packer #(.LATENCY(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_word   (in_word),
        .in_is_key (in_is_key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .datain    (datain),
        .key       (key),
        .blk_valid (blk_valid),
        .key_valid (key_valid),
        .out_valid (out_valid),
        .blk_count (blk_count),
        .err_mix   (err_mix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for pulse timestamps.
    always @(posedge clk) cyc <= cyc + 1;

    // Record pulse times away from the active edge.
    always @(negedge clk) begin
        if (blk_valid) blk_q.push_back(cyc);
        if (out_valid) ov_q.push_back(cyc);
        if (err_mix)   err_n = err_n + 1;
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        in_is_key = 1'b0;
        in_word   = 32'h0;
    endtask

    // Present a word and hold it until accepted (bounded); leaves in_valid high.
    task automatic send_word(input logic [31:0] w, input logic k);
        bit done;
        done      = 1'b0;
        in_word   = w;
        in_is_key = k;
        in_valid  = 1'b1;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check_eq("accept", 128'(done), 128'd1);
    endtask

    task automatic send_block(input logic [127:0] blk, input logic k);
        send_word(blk[127:96], k);
        send_word(blk[95:64],  k);
        send_word(blk[63:32],  k);
        send_word(blk[31:0],   k);
    endtask

    function automatic logic [127:0] pat_block(input int b);
        logic [15:0] bb;
        bb = 16'(b);
        return {bb, 16'h0a00, bb, 16'h0a01, bb, 16'h0a02, bb, 16'h0a03};
    endfunction

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2 = 128'hcafe0000cafe0001cafe0002cafe0003;

    initial begin
        int nb;
        int no;
        int ne;

        rst = 1'b1;
        idle();
        wait_cycles(2);

        // Reset state
        check_eq("rst_key",       key,               128'h0);
        check_eq("rst_datain",    datain,            128'h0);
        check_eq("rst_key_valid", 128'(key_valid),   128'd0);
        check_eq("rst_blk_valid", 128'(blk_valid),   128'd0);
        check_eq("rst_out_valid", 128'(out_valid),   128'd0);
        check_eq("rst_blk_count", 128'(blk_count),   128'd0);
        check_eq("rst_err_mix",   128'(err_mix),     128'd0);
        rst = 1'b0;
        wait_cycles(1);

        // Key load: no block issued
        nb = blk_q.size();
        send_block(KEY1, 1'b1);
        idle();
        wait_cycles(1);
        check_eq("key_load",       key,                          KEY1);
        check_eq("key_valid_set",  128'(key_valid),              128'd1);
        check_eq("key_no_blk",     128'(blk_q.size() - nb),      128'd0);

        // Single plaintext block
        nb = blk_q.size();
        no = ov_q.size();
        send_block(PT1, 1'b0);
        check_eq("pt_blk_valid",   128'(blk_valid),              128'd1);
        check_eq("pt_issue_ready", 128'(in_ready),               128'd0);
        check_eq("pt_datain",      datain,                       PT1);
        idle();
        wait_cycles(1);
        check_eq("pt_blk_one_cyc", 128'(blk_valid),              128'd0);
        wait_cycles(12);
        check_eq("pt_blk_cnt",     128'(blk_q.size() - nb),      128'd1);
        check_eq("pt_ov_cnt",      128'(ov_q.size() - no),       128'd1);
        if (ov_q.size() > no && blk_q.size() > nb)
            check_eq("pt_latency", 128'(ov_q[no] - blk_q[nb]),   128'(LAT));
        check_eq("pt_blk_count",   128'(blk_count),              128'd1);
        check_eq("pt_key_hold",    key,                          KEY1);

        // Reset with key loaded: plaintext refused during and after reset
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_is_key = 1'b0;
        in_word   = 32'h3243f6a8;
        @(negedge clk);
        check_eq("rst_pt_ready",   128'(in_ready),               128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("nokey_ready", 128'(in_ready),              128'd0);
            @(posedge clk);
            #1;
        end
        idle();
        check_eq("nokey_kv",       128'(key_valid),              128'd0);
        check_eq("nokey_datain",   datain,                       128'h0);
        ne = err_n;
        send_block(KEY1, 1'b1);
        idle();
        wait_cycles(1);
        check_eq("reload_key",     key,                          KEY1);
        check_eq("reload_no_err",  128'(err_n - ne),             128'd0);

        // Type mix: 2 plaintext words then a key word
        nb = blk_q.size();
        send_word(32'h11111111, 1'b0);
        send_word(32'h22222222, 1'b0);
        send_word(KEY2[127:96], 1'b1);
        check_eq("mix_err_pulse",  128'(err_mix),                128'd1);
        send_word(KEY2[95:64],  1'b1);
        check_eq("mix_err_once",   128'(err_mix),                128'd0);
        send_word(KEY2[63:32],  1'b1);
        send_word(KEY2[31:0],   1'b1);
        idle();
        wait_cycles(1);
        check_eq("mix_key",        key,                          KEY2);
        check_eq("mix_no_blk",     128'(blk_q.size() - nb),      128'd0);
        check_eq("mix_datain",     datain,                       128'h0);

        // Three blocks at full rate
        nb = blk_q.size();
        no = ov_q.size();
        for (int b = 0; b < 3; b++) send_block(pat_block(b), 1'b0);
        idle();
        wait_cycles(15);
        check_eq("fr_blk_cnt",     128'(blk_q.size() - nb),      128'd3);
        check_eq("fr_ov_cnt",      128'(ov_q.size() - no),       128'd3);
        if (blk_q.size() >= nb + 3 && ov_q.size() >= no + 3) begin
            check_eq("fr_blk_gap1", 128'(blk_q[nb+1] - blk_q[nb]),   128'd5);
            check_eq("fr_blk_gap2", 128'(blk_q[nb+2] - blk_q[nb+1]), 128'd5);
            check_eq("fr_ov_gap1",  128'(ov_q[no+1] - ov_q[no]),     128'd5);
            check_eq("fr_ov_gap2",  128'(ov_q[no+2] - ov_q[no+1]),   128'd5);
            check_eq("fr_lat",      128'(ov_q[no] - blk_q[nb]),      128'(LAT));
        end
        check_eq("fr_datain",      datain,                       pat_block(2));

        // Reset after the 2nd block of a stream: in-flight blocks vanish
        nb = blk_q.size();
        no = ov_q.size();
        send_block(pat_block(10), 1'b0);
        send_block(pat_block(11), 1'b0);
        rst       = 1'b1;
        in_word   = 32'h33333333;
        in_is_key = 1'b0;
        in_valid  = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        idle();
        wait_cycles(15);
        check_eq("rr_blk_cnt",     128'(blk_q.size() - nb),      128'd2);
        check_eq("rr_no_ov",       128'(ov_q.size() - no),       128'd0);
        check_eq("rr_key",         key,                          128'h0);
        check_eq("rr_datain",      datain,                       128'h0);
        check_eq("rr_key_valid",   128'(key_valid),              128'd0);
        check_eq("rr_blk_count",   128'(blk_count),              128'd0);
        check_eq("rr_out_valid",   128'(out_valid),              128'd0);

        // 256 blocks: blk_count wraps on the 256th out_valid
        send_block(KEY1, 1'b1);
        idle();
        wait_cycles(1);
        no = ov_q.size();
        for (int b = 0; b < 256; b++) send_block(pat_block(b), 1'b0);
        idle();
        wait_cycles(7);
        check_eq("wrap_255",       128'(blk_count),              128'd255);
        wait_cycles(4);
        check_eq("wrap_0",         128'(blk_count),              128'd0);
        check_eq("wrap_ov_cnt",    128'(ov_q.size() - no),       128'd256);
        check_eq("wrap_datain",    datain,                       pat_block(255));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: stop a stuck run with a reported failure.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/aes_input_packer.md
AES_INPUT_PACKER -- requirements
Module: aes_input_packer

Interface
REQ-001 SHALL have parameter LATENCY, default 10, meaning the number of clk cycles from cipher input capture to valid cipher dataout (range 1..32).
REQ-002 SHALL have port clk  input  1  single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_word  input  32  word of key or plaintext, most-significant word first.
REQ-005 SHALL have port in_is_key  input  1  1 = in_word is a key word, 0 = plaintext word.
REQ-006 SHALL have port in_valid  input  1  in_word/in_is_key are valid this cycle.
REQ-007 SHALL have port in_ready  output  1  packer accepts a word this cycle.
REQ-008 SHALL have port datain  output  128  plaintext block to the cipher core.
REQ-009 SHALL have port key  output  128  cipher key to the cipher core.
REQ-010 SHALL have port blk_valid  output  1  one-cycle pulse: datain/key form a new block this cycle.
REQ-011 SHALL have port key_valid  output  1  a complete 128-bit key has been loaded since reset.
REQ-012 SHALL have port out_valid  output  1  cipher dataout is valid this cycle (delayed blk_valid).
REQ-013 SHALL have port blk_count  output  8  number of out_valid pulses since reset, modulo 256.
REQ-014 SHALL have port err_mix  output  1  one-cycle pulse: partial block discarded due to word-type change.

Function
REQ-015 SHALL accept a word on any clk edge where in_valid && in_ready.
REQ-016 SHALL drive in_ready = (state != ISSUE) && (in_is_key || key_valid); plaintext is refused until a key exists.
REQ-017 SHALL implement states IDLE, FILL_KEY, FILL_DATA, ISSUE and a 2-bit word counter wcnt.
REQ-018 SHALL, in IDLE on acceptance, store the word in shadow bits [127:96], set wcnt=1, go to FILL_KEY if in_is_key else FILL_DATA.
REQ-019 SHALL, in FILL_x on acceptance of the same type, store word k at bits [127-32k:96-32k] and increment wcnt.
REQ-020 SHALL, when the 4th key word is accepted, copy the shadow into key, set key_valid=1, set wcnt=0, return to IDLE; key changes at no other time.
REQ-021 SHALL, when the 4th plaintext word is accepted, copy the shadow into datain, set wcnt=0, and enter ISSUE.
REQ-022 SHALL, in ISSUE, assert blk_valid for exactly one cycle with in_ready=0, then return to IDLE; datain and key hold their values until the next update.
REQ-023 SHALL, in FILL_x when an accepted word has the other type, discard the partial block, pulse err_mix for one cycle, and treat the word as word 0 of a new block of its type.
REQ-024 SHALL give a key reload between blocks no effect on blocks already issued; only key at the blk_valid cycle is used.
REQ-025 SHALL delay blk_valid through a LATENCY-deep shift register; out_valid = its last stage, exactly LATENCY cycles after blk_valid.
REQ-026 SHALL support back-to-back issue (one block per 5 cycles at full rate), with up to ceil(LATENCY/5) blocks in flight, each tracked independently.
REQ-027 SHALL increment blk_count on each out_valid, wrapping 255 -> 0.
REQ-028 SHALL ignore in_word/in_is_key when in_valid=0, regardless of state.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, set state=IDLE, wcnt=0, shadow=0, datain=0, key=0, key_valid=0, blk_valid=0, err_mix=0, shift register=0, out_valid=0, blk_count=0.
REQ-030 SHALL, on reset mid-fill or with blocks in flight, discard partial words and in-flight valids; no out_valid fires for pre-reset blocks.
REQ-031 SHALL drive in_ready=0 during a reset cycle for plaintext words, since key_valid is forced to 0.

Verification
REQ-032 SHALL check: after reset, 4 key words 0x2b7e1516,0x28aed2a6,0xabf71588,0x09cf4f3c -> key=2b7e151628aed2a6abf7158809cf4f3c, key_valid=1, blk_valid stays 0.
REQ-033 SHALL check: then plaintext 0x3243f6a8,0x885a308d,0x313198a2,0xe0370734 -> datain=3243f6a8885a308d313198a2e0370734, blk_valid one cycle, out_valid exactly 10 cycles later, blk_count=1.
REQ-034 SHALL check: plaintext with in_valid=1 before any key -> in_ready=0, no state change.
REQ-035 SHALL check: 2 plaintext words then 1 key word -> err_mix pulse, partial data dropped, key shadow word 0 = that key word, no blk_valid.
REQ-036 SHALL check: 3 blocks streamed at full rate -> 3 blk_valid pulses 5 cycles apart, 3 out_valid pulses 5 cycles apart; rst asserted after 2nd blk_valid -> no further out_valid, all outputs 0.
REQ-037 SHALL check: 256 blocks -> blk_count wraps to 0 on the 256th out_valid.
